// File: rtl/utils_pkg.sv
// Shared core-bus types: request/response structs, response codes, master IDs.
package utils_pkg;

  typedef enum logic [1:0] {
    CB_OKAY   = 2'b00,
    CB_EXOKAY = 2'b01,
    CB_SLVERR = 2'b10,
    CB_DECERR = 2'b11
  } cb_resp_t;

  typedef enum logic {
    CB_M_INSTR = 1'b0,
    CB_M_LSU   = 1'b1
  } cb_master_id_t;

  typedef struct packed {
    logic        rd_addr_valid;
    logic [31:0] rd_addr;
    logic [1:0]  rd_size;
    logic        rd_ready;
    logic        wr_addr_valid;
    logic [31:0] wr_addr;
    logic [1:0]  wr_size;
    logic        wr_data_valid;
    logic [31:0] wr_data;
    logic [3:0]  wr_strobe;
    logic        wr_resp_ready;
  } s_cb_mosi_t;

  typedef struct packed {
    logic        rd_addr_ready;
    logic        rd_valid;
    logic [31:0] rd_data;
    cb_resp_t    rd_resp;
    logic        wr_addr_ready;
    logic        wr_data_ready;
    logic        wr_resp_valid;
    cb_resp_t    wr_resp;
  } s_cb_miso_t;

endpackage

// File: rtl/fifo.sv
// Small synchronous FIFO; push while full is accepted only when a pop frees a slot in the same cycle.
module fifo #(
  parameter int unsigned SLOTS = 4,
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PW = $clog2(SLOTS);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;
  logic [WIDTH-1:0] mem_q [SLOTS];
  logic [WIDTH-1:0] mem_d [SLOTS];
  logic             do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(SLOTS));
  assign empty_o = (count_q == '0);
  assign data_o  = mem_q[rd_ptr_q];

  // Next pointers, occupancy and storage.
  always_comb begin
    do_pop   = pop_i && !empty_o;
    do_push  = push_i && (!full_o || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (do_push && !do_pop) begin
      count_d = count_q + (PW+1)'(1);
    end else if (do_pop && !do_push) begin
      count_d = count_q - (PW+1)'(1);
    end
  end

  // Pointer/occupancy registers; reset empties the queue.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/cb_rd_arbiter.sv
// Read-channel arbiter between fetch and LSU onto one core bus, with in-order response routing.
module cb_rd_arbiter
  import utils_pkg::*;
#(
  parameter int unsigned MAX_OT_TXN = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  s_cb_mosi_t instr_cb_mosi_i,
  output s_cb_miso_t instr_cb_miso_o,
  input  s_cb_mosi_t lsu_cb_mosi_i,
  output s_cb_miso_t lsu_cb_miso_o,
  output s_cb_mosi_t cb_mosi_o,
  input  s_cb_miso_t cb_miso_i,
  output logic       ot_full_o,
  output logic       resp_err_o
);

  logic          lock_q, lock_d;
  cb_master_id_t lock_id_q, lock_id_d;
  cb_master_id_t last_q, last_d;
  cb_master_id_t grant_id, head_id;
  logic [0:0]    grant_raw, head_raw;
  logic          grant_req, addr_open, addr_valid, addr_hs;
  logic          q_full, q_empty, rsp_valid, head_rd_ready, pop;
  logic          unused_instr_wr;

  assign unused_instr_wr = ^{instr_cb_mosi_i.wr_addr_valid, instr_cb_mosi_i.wr_addr,
                             instr_cb_mosi_i.wr_size, instr_cb_mosi_i.wr_data_valid,
                             instr_cb_mosi_i.wr_data, instr_cb_mosi_i.wr_strobe,
                             instr_cb_mosi_i.wr_resp_ready};

  // Response side: head ownership, pop, and the address-window gate (full is judged after pop).
  always_comb begin
    head_id       = cb_master_id_t'(head_raw);
    head_rd_ready = (head_id == CB_M_LSU) ? lsu_cb_mosi_i.rd_ready : instr_cb_mosi_i.rd_ready;
    rsp_valid     = cb_miso_i.rd_valid && !rst;
    pop           = rsp_valid && !q_empty && head_rd_ready;
    addr_open     = !rst && (!q_full || pop);
  end

  // Round-robin grant; a pending unaccepted request keeps the grant until its handshake.
  always_comb begin
    grant_id = CB_M_INSTR;
    if (lock_q && ((lock_id_q == CB_M_LSU) ? lsu_cb_mosi_i.rd_addr_valid
                                           : instr_cb_mosi_i.rd_addr_valid)) begin
      grant_id = lock_id_q;
    end else if (instr_cb_mosi_i.rd_addr_valid && lsu_cb_mosi_i.rd_addr_valid) begin
      grant_id = (last_q == CB_M_INSTR) ? CB_M_LSU : CB_M_INSTR;
    end else if (lsu_cb_mosi_i.rd_addr_valid) begin
      grant_id = CB_M_LSU;
    end
    grant_raw  = grant_id;
    grant_req  = (grant_id == CB_M_LSU) ? lsu_cb_mosi_i.rd_addr_valid
                                        : instr_cb_mosi_i.rd_addr_valid;
    addr_valid = grant_req && addr_open;
    addr_hs    = addr_valid && cb_miso_i.rd_addr_ready;
    lock_d     = grant_req && !addr_hs;
    lock_id_d  = grant_id;
    last_d     = addr_hs ? grant_id : last_q;
  end

  // Arbitration state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      lock_q    <= 1'b0;
      lock_id_q <= CB_M_INSTR;
      last_q    <= CB_M_INSTR;
    end else begin
      lock_q    <= lock_d;
      lock_id_q <= lock_id_d;
      last_q    <= last_d;
    end
  end

  fifo #(
    .SLOTS (MAX_OT_TXN),
    .WIDTH (1)
  ) u_order_q (
    .clk     (clk),
    .rst     (rst),
    .push_i  (addr_hs),
    .data_i  (grant_raw),
    .pop_i   (pop),
    .data_o  (head_raw),
    .full_o  (q_full),
    .empty_o (q_empty)
  );

  // Bus-side request mux, response demux and LSU write-channel passthrough.
  always_comb begin
    cb_mosi_o       = '0;
    instr_cb_miso_o = '0;
    lsu_cb_miso_o   = '0;

    cb_mosi_o.rd_addr_valid = addr_valid;
    cb_mosi_o.rd_addr       = (grant_id == CB_M_LSU) ? lsu_cb_mosi_i.rd_addr : instr_cb_mosi_i.rd_addr;
    cb_mosi_o.rd_size       = (grant_id == CB_M_LSU) ? lsu_cb_mosi_i.rd_size : instr_cb_mosi_i.rd_size;
    cb_mosi_o.rd_ready      = q_empty ? 1'b1 : head_rd_ready;
    cb_mosi_o.wr_addr_valid = lsu_cb_mosi_i.wr_addr_valid && !rst;
    cb_mosi_o.wr_addr       = lsu_cb_mosi_i.wr_addr;
    cb_mosi_o.wr_size       = lsu_cb_mosi_i.wr_size;
    cb_mosi_o.wr_data_valid = lsu_cb_mosi_i.wr_data_valid && !rst;
    cb_mosi_o.wr_data       = lsu_cb_mosi_i.wr_data;
    cb_mosi_o.wr_strobe     = lsu_cb_mosi_i.wr_strobe;
    cb_mosi_o.wr_resp_ready = lsu_cb_mosi_i.wr_resp_ready;

    instr_cb_miso_o.rd_addr_ready = addr_open && cb_miso_i.rd_addr_ready && (grant_id == CB_M_INSTR);
    instr_cb_miso_o.rd_valid      = rsp_valid && !q_empty && (head_id == CB_M_INSTR);
    instr_cb_miso_o.rd_data       = cb_miso_i.rd_data;
    instr_cb_miso_o.rd_resp       = cb_miso_i.rd_resp;

    lsu_cb_miso_o.rd_addr_ready = addr_open && cb_miso_i.rd_addr_ready && (grant_id == CB_M_LSU);
    lsu_cb_miso_o.rd_valid      = rsp_valid && !q_empty && (head_id == CB_M_LSU);
    lsu_cb_miso_o.rd_data       = cb_miso_i.rd_data;
    lsu_cb_miso_o.rd_resp       = cb_miso_i.rd_resp;
    lsu_cb_miso_o.wr_addr_ready = cb_miso_i.wr_addr_ready;
    lsu_cb_miso_o.wr_data_ready = cb_miso_i.wr_data_ready;
    lsu_cb_miso_o.wr_resp_valid = cb_miso_i.wr_resp_valid;
    lsu_cb_miso_o.wr_resp       = cb_miso_i.wr_resp;

    ot_full_o  = q_full && !rst;
    resp_err_o = rsp_valid && q_empty;
  end

endmodule

// File: tb/tb_cb_rd_arbiter.sv
// Directed bench for cb_rd_arbiter: arbitration, locking, queue-full, response routing, reset.
module tb_cb_rd_arbiter;
  import utils_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  s_cb_mosi_t instr_mosi, lsu_mosi, cb_mosi;
  s_cb_miso_t instr_miso, lsu_miso, cb_miso;
  logic       ot_full, resp_err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  cb_rd_arbiter #(.MAX_OT_TXN(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .instr_cb_mosi_i (instr_mosi),
    .instr_cb_miso_o (instr_miso),
    .lsu_cb_mosi_i   (lsu_mosi),
    .lsu_cb_miso_o   (lsu_miso),
    .cb_mosi_o       (cb_mosi),
    .cb_miso_i       (cb_miso),
    .ot_full_o       (ot_full),
    .resp_err_o      (resp_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    instr_mosi = '0;
    lsu_mosi   = '0;
    cb_miso    = '0;
    instr_mosi.rd_ready = 1'b1;
    lsu_mosi.rd_ready   = 1'b1;

    // Reset: outputs held quiet even with live inputs.
    rst = 1'b1;
    instr_mosi.rd_addr_valid = 1'b1;
    instr_mosi.rd_addr = 32'h44;
    cb_miso.rd_valid = 1'b1;
    cb_miso.rd_addr_ready = 1'b1;
    settle();
    check("rst_ot_full", ot_full, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_addr_valid", cb_mosi.rd_addr_valid, 0);
    step();
    step();
    instr_mosi.rd_addr_valid = 1'b0;
    cb_miso.rd_valid = 1'b0;
    rst = 1'b0;
    settle();
    check("post_rst_ot_full", ot_full, 0);
    check("empty_rd_ready", cb_mosi.rd_ready, 1);

    // Tie: LSU wins first after reset, then fetch.
    instr_mosi.rd_addr_valid = 1'b1; instr_mosi.rd_addr = 32'h100;
    lsu_mosi.rd_addr_valid   = 1'b1; lsu_mosi.rd_addr   = 32'h2000;
    settle();
    check("tie_c0_addr", cb_mosi.rd_addr, 32'h2000);
    check("tie_c0_lsu_rdy", lsu_miso.rd_addr_ready, 1);
    check("tie_c0_instr_rdy", instr_miso.rd_addr_ready, 0);
    step();
    lsu_mosi.rd_addr_valid = 1'b0;
    settle();
    check("tie_c1_addr", cb_mosi.rd_addr, 32'h100);
    check("tie_c1_instr_rdy", instr_miso.rd_addr_ready, 1);
    step();
    instr_mosi.rd_addr_valid = 1'b0;
    cb_miso.rd_valid = 1'b1; cb_miso.rd_data = 32'h1111_1111;
    settle();
    check("q0_lsu_valid", lsu_miso.rd_valid, 1);
    check("q0_instr_valid", instr_miso.rd_valid, 0);
    check("q0_lsu_data", lsu_miso.rd_data, 32'h1111_1111);
    step();
    cb_miso.rd_data = 32'h2222_2222;
    settle();
    check("q1_instr_valid", instr_miso.rd_valid, 1);
    check("q1_lsu_valid", lsu_miso.rd_valid, 0);
    step();
    cb_miso.rd_valid = 1'b0;

    // Lock: fetch held at 0x80 across three not-ready cycles.
    cb_miso.rd_addr_ready = 1'b0;
    instr_mosi.rd_addr_valid = 1'b1; instr_mosi.rd_addr = 32'h80;
    settle();
    check("lock_c0_addr", cb_mosi.rd_addr, 32'h80);
    step();
    lsu_mosi.rd_addr_valid = 1'b1; lsu_mosi.rd_addr = 32'h300;
    settle();
    check("lock_c1_addr", cb_mosi.rd_addr, 32'h80);
    check("lock_c1_lsu_rdy", lsu_miso.rd_addr_ready, 0);
    step();
    settle();
    check("lock_c2_addr", cb_mosi.rd_addr, 32'h80);
    step();
    cb_miso.rd_addr_ready = 1'b1;
    settle();
    check("lock_acc_addr", cb_mosi.rd_addr, 32'h80);
    check("lock_acc_instr_rdy", instr_miso.rd_addr_ready, 1);
    step();
    instr_mosi.rd_addr_valid = 1'b0;
    settle();
    check("lock_next_addr", cb_mosi.rd_addr, 32'h300);
    check("lock_next_lsu_rdy", lsu_miso.rd_addr_ready, 1);
    step();
    lsu_mosi.rd_addr_valid = 1'b0;
    cb_miso.rd_valid = 1'b1;
    step();
    step();
    cb_miso.rd_valid = 1'b0;

    // Full: four fetch reads, then a response frees a slot for a fifth.
    instr_mosi.rd_addr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      instr_mosi.rd_addr = 32'h1000 + 32'(4 * i);
      step();
    end
    instr_mosi.rd_addr = 32'h1010;
    settle();
    check("full_ot_full", ot_full, 1);
    check("full_addr_valid", cb_mosi.rd_addr_valid, 0);
    check("full_instr_rdy", instr_miso.rd_addr_ready, 0);
    cb_miso.rd_valid = 1'b1; cb_miso.rd_data = 32'hDEAD_BEEF;
    settle();
    check("full_pop_valid", instr_miso.rd_valid, 1);
    check("full_pop_data", instr_miso.rd_data, 32'hDEAD_BEEF);
    check("full_pop_addr_valid", cb_mosi.rd_addr_valid, 1);
    check("full_pop_instr_rdy", instr_miso.rd_addr_ready, 1);
    step();
    cb_miso.rd_valid = 1'b0;
    instr_mosi.rd_addr_valid = 1'b0;
    settle();
    check("full_after_swap", ot_full, 1);
    cb_miso.rd_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    cb_miso.rd_valid = 1'b0;
    settle();
    check("drained_ot_full", ot_full, 0);

    // Interleaved IDs [0,1,0] with data A,B,C; LSU backpressure.
    instr_mosi.rd_addr_valid = 1'b1; instr_mosi.rd_addr = 32'h40;
    step();
    instr_mosi.rd_addr_valid = 1'b0;
    lsu_mosi.rd_addr_valid = 1'b1; lsu_mosi.rd_addr = 32'h50;
    step();
    lsu_mosi.rd_addr_valid = 1'b0;
    instr_mosi.rd_addr_valid = 1'b1; instr_mosi.rd_addr = 32'h60;
    step();
    instr_mosi.rd_addr_valid = 1'b0;
    cb_miso.rd_valid = 1'b1; cb_miso.rd_data = 32'hAAAA_0001;
    settle();
    check("il_a_instr", instr_miso.rd_valid, 1);
    check("il_a_lsu", lsu_miso.rd_valid, 0);
    step();
    cb_miso.rd_data = 32'hBBBB_0002;
    lsu_mosi.rd_ready = 1'b0;
    settle();
    check("il_b_stall_rdy", cb_mosi.rd_ready, 0);
    check("il_b_stall_lsu", lsu_miso.rd_valid, 1);
    step();
    lsu_mosi.rd_ready = 1'b1;
    settle();
    check("il_b_lsu", lsu_miso.rd_valid, 1);
    check("il_b_instr", instr_miso.rd_valid, 0);
    check("il_b_rdy", cb_mosi.rd_ready, 1);
    step();
    cb_miso.rd_data = 32'hCCCC_0003;
    settle();
    check("il_c_instr", instr_miso.rd_valid, 1);
    check("il_c_lsu", lsu_miso.rd_valid, 0);
    check("il_c_data", instr_miso.rd_data, 32'hCCCC_0003);
    step();
    cb_miso.rd_valid = 1'b0;

    // Stray response with empty queue.
    instr_mosi.rd_ready = 1'b0;
    lsu_mosi.rd_ready = 1'b0;
    settle();
    check("empty_rd_ready_forced", cb_mosi.rd_ready, 1);
    instr_mosi.rd_ready = 1'b1;
    lsu_mosi.rd_ready = 1'b1;
    cb_miso.rd_valid = 1'b1;
    settle();
    check("stray_err", resp_err, 1);
    check("stray_instr", instr_miso.rd_valid, 0);
    check("stray_lsu", lsu_miso.rd_valid, 0);
    step();
    cb_miso.rd_valid = 1'b0;
    settle();
    check("stray_err_clear", resp_err, 0);

    // Error response passes through and pops.
    instr_mosi.rd_addr_valid = 1'b1; instr_mosi.rd_addr = 32'h90;
    step();
    instr_mosi.rd_addr_valid = 1'b0;
    cb_miso.rd_valid = 1'b1; cb_miso.rd_resp = CB_SLVERR;
    settle();
    check("err_rsp_valid", instr_miso.rd_valid, 1);
    check("err_rsp_code", instr_miso.rd_resp, 2'b10);
    step();
    cb_miso.rd_resp = CB_OKAY;
    settle();
    check("err_rsp_popped", resp_err, 1);
    step();
    cb_miso.rd_valid = 1'b0;

    // Reset with two reads outstanding.
    instr_mosi.rd_addr_valid = 1'b1; instr_mosi.rd_addr = 32'h70;
    step();
    instr_mosi.rd_addr_valid = 1'b0;
    lsu_mosi.rd_addr_valid = 1'b1; lsu_mosi.rd_addr = 32'h74;
    step();
    lsu_mosi.rd_addr_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    settle();
    check("midrst_ot_full", ot_full, 0);
    cb_miso.rd_valid = 1'b1;
    settle();
    check("midrst_err", resp_err, 1);
    check("midrst_instr", instr_miso.rd_valid, 0);
    step();
    cb_miso.rd_valid = 1'b0;

    // LSU write channel passthrough; fetch write fields stay zero.
    lsu_mosi.wr_addr_valid = 1'b1; lsu_mosi.wr_addr = 32'hABC;
    lsu_mosi.wr_data_valid = 1'b1; lsu_mosi.wr_data = 32'h1234_5678;
    cb_miso.wr_resp_valid = 1'b1; cb_miso.wr_resp = CB_DECERR;
    settle();
    check("wr_addr_valid", cb_mosi.wr_addr_valid, 1);
    check("wr_addr", cb_mosi.wr_addr, 32'hABC);
    check("wr_data", cb_mosi.wr_data, 32'h1234_5678);
    check("wr_resp_valid", lsu_miso.wr_resp_valid, 1);
    check("wr_resp", lsu_miso.wr_resp, 2'b11);
    check("instr_wr_resp_valid", instr_miso.wr_resp_valid, 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
